// File: rtl/stream_dmux.sv
// stream_dmux: 1-to-CH valid/ready stream demultiplexer with one registered slot per channel.
// Optional packet-lock mode (select held for a whole packet) is compiled in with STREAM_DMUX_LOCK_EN.
module stream_dmux #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CH    = 4,
    parameter int unsigned SW    = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [WIDTH-1:0]      IN,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [SW-1:0]         S,
`ifdef STREAM_DMUX_LOCK_EN
    input  logic                  IN_LAST,
`endif
    output logic [CH*WIDTH-1:0]   Y,
    output logic [CH-1:0]         Y_VALID,
    input  logic [CH-1:0]         Y_READY,
    output logic                  ERR
);

    logic [SW-1:0] sel;
    logic [CH-1:0] hit;
    logic          in_range;
    logic          xfer;

`ifdef STREAM_DMUX_LOCK_EN
    typedef enum logic {IDLE, LOCKED} lock_state_t;

    lock_state_t   state;
    logic [SW-1:0] lock_sel;

    assign sel = (state == LOCKED) ? lock_sel : S;

    // Packet lock: a non-last beat pins the select until the last beat is consumed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            lock_sel <= '0;
        end else if (xfer) begin
            case (state)
                IDLE: begin
                    if (!IN_LAST) begin
                        state    <= LOCKED;
                        lock_sel <= S;
                    end
                end
                LOCKED: begin
                    if (IN_LAST) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign sel = S;
`endif

    // One-hot channel decode; an all-zero result means the select is out of range.
    always_comb begin
        hit = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            hit[k] = (32'(sel) == k);
        end
    end

    assign in_range = |hit;
    assign IN_READY = !RST && (!in_range || (|(hit & (~Y_VALID | Y_READY))));
    assign xfer     = IN_VALID && IN_READY;

    // Slot update: a load wins over a drain so a simultaneous drain+load keeps the slot full.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Y       <= '0;
            Y_VALID <= '0;
            ERR     <= 1'b0;
        end else begin
            ERR <= xfer && !in_range;
            for (int unsigned k = 0; k < CH; k++) begin
                if (xfer && hit[k]) begin
                    Y[k*WIDTH +: WIDTH] <= IN;
                    Y_VALID[k]          <= 1'b1;
                end else if (Y_READY[k]) begin
                    Y_VALID[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_dmux.sv
// Self-checking bench for stream_dmux: vector table on a 4-channel instance, directed and
// randomized scoreboard checks on a 3-channel instance (out-of-range selects possible).
module tb_stream_dmux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 4-channel instance
    logic        rst4 = 1'b1;
    logic [7:0]  in4  = '0;
    logic        v4   = 1'b0;
    logic        rdy4;
    logic [1:0]  s4   = '0;
    logic        last4 = 1'b1;
    logic [31:0] y4;
    logic [3:0]  yv4;
    logic [3:0]  yr4  = '0;
    logic        err4;

    // 3-channel instance
    logic        rst3 = 1'b1;
    logic [7:0]  in3  = '0;
    logic        v3   = 1'b0;
    logic        rdy3;
    logic [1:0]  s3   = '0;
    logic        last3 = 1'b1;
    logic [23:0] y3;
    logic [2:0]  yv3;
    logic [2:0]  yr3  = '0;
    logic        err3;

    stream_dmux #(.WIDTH(8), .CH(4), .SW(2)) dut4 (
        .CLK(clk), .RST(rst4), .IN(in4), .IN_VALID(v4), .IN_READY(rdy4), .S(s4),
`ifdef STREAM_DMUX_LOCK_EN
        .IN_LAST(last4),
`endif
        .Y(y4), .Y_VALID(yv4), .Y_READY(yr4), .ERR(err4)
    );

    stream_dmux #(.WIDTH(8), .CH(3), .SW(2)) dut3 (
        .CLK(clk), .RST(rst3), .IN(in3), .IN_VALID(v3), .IN_READY(rdy3), .S(s3),
`ifdef STREAM_DMUX_LOCK_EN
        .IN_LAST(last3),
`endif
        .Y(y3), .Y_VALID(yv3), .Y_READY(yr3), .ERR(err3)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [1:0]  s;
        logic [7:0]  d;
        logic [3:0]  yr;
        logic        rdy;   // IN_READY before the edge
        logic [3:0]  yv;    // after the edge
        logic [31:0] y;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic vld, input logic [1:0] s,
                                input logic [7:0] d, input logic [3:0] yr, input logic rdy,
                                input logic [3:0] yv, input logic [31:0] y, input logic err);
        vec_t r;
        r.rst = rst; r.vld = vld; r.s = s; r.d = d; r.yr = yr;
        r.rdy = rdy; r.yv = yv; r.y = y; r.err = err;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_q[3][$];
    logic       exp_rdy;
    logic       exp_err;
    int         sel;

    initial begin
        // Reset, routing, backpressure, throughput, reset during a stall.
        tbl.push_back(mk(1, 0, 0, 8'h00, 4'h0, 0, 4'b0000, 32'h0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 4'h0, 0, 4'b0000, 32'h0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'hF, 1, 4'b0000, 32'h0, 0));
        tbl.push_back(mk(0, 1, 0, 8'hA0, 4'hF, 1, 4'b0001, 32'h000000A0, 0));
        tbl.push_back(mk(0, 1, 1, 8'hA1, 4'hF, 1, 4'b0010, 32'h0000A1A0, 0));
        tbl.push_back(mk(0, 1, 2, 8'hA2, 4'hF, 1, 4'b0100, 32'h00A2A1A0, 0));
        tbl.push_back(mk(0, 1, 3, 8'hA3, 4'hF, 1, 4'b1000, 32'hA3A2A1A0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'hF, 1, 4'b0000, 32'hA3A2A1A0, 0));
        tbl.push_back(mk(0, 1, 2, 8'h55, 4'hB, 1, 4'b0100, 32'hA355A1A0, 0));
        tbl.push_back(mk(0, 1, 2, 8'h66, 4'hB, 0, 4'b0100, 32'hA355A1A0, 0));
        tbl.push_back(mk(0, 1, 1, 8'h77, 4'hB, 1, 4'b0110, 32'hA35577A0, 0));
        tbl.push_back(mk(0, 1, 2, 8'h66, 4'hF, 1, 4'b0100, 32'hA36677A0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'hF, 1, 4'b0000, 32'hA36677A0, 0));
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk(0, 1, 0, 8'(8'h80 + i), 4'hF, 1, 4'b0001,
                             {24'hA36677, 8'(8'h80 + i)}, 0));
        end
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'hF, 1, 4'b0000, 32'hA3667787, 0));
        tbl.push_back(mk(0, 1, 3, 8'h99, 4'h0, 1, 4'b1000, 32'h99667787, 0));
        tbl.push_back(mk(0, 1, 3, 8'hAA, 4'h0, 0, 4'b1000, 32'h99667787, 0));
        tbl.push_back(mk(1, 1, 3, 8'hAA, 4'h0, 0, 4'b0000, 32'h0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'h0, 1, 4'b0000, 32'h0, 0));

        foreach (tbl[i]) begin
            rst4 = tbl[i].rst; v4 = tbl[i].vld; s4 = tbl[i].s; in4 = tbl[i].d; yr4 = tbl[i].yr;
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(rdy4), 32'(tbl[i].rdy));
            step();
            check($sformatf("vec%0d_y_valid", i), 32'(yv4), 32'(tbl[i].yv));
            check($sformatf("vec%0d_y", i), y4, tbl[i].y);
            check($sformatf("vec%0d_err", i), 32'(err4), 32'(tbl[i].err));
        end

`ifdef STREAM_DMUX_LOCK_EN
        // Packet lock: select pinned to the first beat's channel until IN_LAST.
        yr4 = 4'hF; v4 = 1'b1;
        in4 = 8'h10; s4 = 2'd1; last4 = 1'b0; step();
        check("lock_b0_valid", 32'(yv4), 32'b0010); check("lock_b0_data", 32'(y4[15:8]), 32'h10);
        in4 = 8'h11; s4 = 2'd3; last4 = 1'b0; step();
        check("lock_b1_valid", 32'(yv4), 32'b0010); check("lock_b1_data", 32'(y4[15:8]), 32'h11);
        in4 = 8'h12; s4 = 2'd0; last4 = 1'b1; step();
        check("lock_b2_valid", 32'(yv4), 32'b0010); check("lock_b2_data", 32'(y4[15:8]), 32'h12);
        in4 = 8'h13; s4 = 2'd2; last4 = 1'b1; step();
        check("lock_next_valid", 32'(yv4), 32'b0100);
        in4 = 8'h20; s4 = 2'd1; last4 = 1'b0; step();
        v4 = 1'b0; rst4 = 1'b1; step();
        rst4 = 1'b0; v4 = 1'b1; in4 = 8'h21; s4 = 2'd2; last4 = 1'b1; step();
        check("lock_rst_valid", 32'(yv4), 32'b0100); check("lock_rst_data", 32'(y4[23:16]), 32'h21);
        v4 = 1'b0;
`endif

        // Out-of-range select on a 3-channel build.
        rst3 = 1'b0; step();
        v3 = 1'b1; s3 = 2'd0; in3 = 8'h11; yr3 = 3'b000;
        #1; check("oor_pre_ready", 32'(rdy3), 32'h1);
        step();
        check("oor_pre_valid", 32'(yv3), 32'b001);
        s3 = 2'd3; in3 = 8'hEE;
        #1; check("oor_ready", 32'(rdy3), 32'h1);
        step();
        check("oor_err_high", 32'(err3), 32'h1);
        check("oor_valid_kept", 32'(yv3), 32'b001);
        check("oor_data_kept", 32'(y3), 32'h000011);
        v3 = 1'b0; step();
        check("oor_err_pulse", 32'(err3), 32'h0);
        check("oor_valid_still", 32'(yv3), 32'b001);

        // Randomized traffic against a per-channel queue scoreboard.
        rst3 = 1'b1; step(); rst3 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            v3 = 1'($urandom_range(0, 1)); s3 = 2'($urandom_range(0, 3));
            in3 = 8'($urandom); yr3 = 3'($urandom);
            #1;
            sel = int'(s3);
            if (sel >= 3) exp_rdy = 1'b1;
            else exp_rdy = (exp_q[sel].size() == 0) || yr3[sel];
            check("rand_in_ready", 32'(rdy3), 32'(exp_rdy));
            exp_err = v3 && (sel >= 3);
            for (int k = 0; k < 3; k++) begin
                if (exp_q[k].size() > 0 && yr3[k]) void'(exp_q[k].pop_front());
            end
            if (v3 && exp_rdy && sel < 3) exp_q[sel].push_back(in3);
            step();
            check("rand_err", 32'(err3), 32'(exp_err));
            for (int k = 0; k < 3; k++) begin
                check($sformatf("rand_valid%0d", k), 32'(yv3[k]), 32'(exp_q[k].size() > 0));
                if (exp_q[k].size() > 0)
                    check($sformatf("rand_data%0d", k), 32'(y3[k*8 +: 8]), 32'(exp_q[k][0]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_dmux.md
# stream_dmux

Parametrised 1-to-CH stream demultiplexer with valid/ready handshaking and one registered output slot per channel. It is the successor to the combinational 1:4 DMUX: the data width and channel count are generalised, and each output holds its beat until that channel's sink accepts it. It sits between a single producer and CH independent consumers. An optional packet-lock mode keeps the select fixed for the whole of a multi-beat packet.

## Interface
- WIDTH, default 8: data width per beat.
- CH, default 4: number of output channels, at least 2.
- SW, default 2: select width; requires 2^SW >= CH.
- CLK, input, 1: rising-edge clock.
- RST, input, 1: synchronous reset, active-high. One clock, no other reset.
- IN, input, WIDTH: input data beat.
- IN_VALID, input, 1: input beat is valid.
- IN_READY, output, 1: block can accept the beat this cycle.
- S, input, SW: channel select, sampled together with the IN beat.
- IN_LAST, input, 1: last beat of a packet. Present only with STREAM_DMUX_LOCK_EN.
- Y, output, CH*WIDTH: channel k's data occupies Y[k*WIDTH +: WIDTH].
- Y_VALID, output, CH: per-channel valid.
- Y_READY, input, CH: per-channel sink ready.
- ERR, output, 1: one-cycle pulse when an out-of-range select is dropped.

## Operation
- Each channel k has one slot: a data register plus a full flag. Y_VALID[k] is the full flag.
- The effective select E is S, or the locked select when lock mode is active (see Configuration).
- E < CH:
  - IN_READY = !full[E] | Y_READY[E].
  - A transfer happens when IN_VALID & IN_READY. On a transfer the slot for E loads IN and stays full.
- E >= CH:
  - IN_READY = 1.
  - A beat with IN_VALID is consumed and discarded, and ERR pulses high on the next cycle.
  - No channel slot changes.
- Channel drain: when Y_VALID[k] & Y_READY[k] and no new load targets k, full[k] clears on the next edge.
- Simultaneous drain and load on the same channel: the slot reloads with the new beat and stays full. No bubble, no loss.
- Channels drain independently. A stalled channel never blocks a transfer to a different channel.
- Y[k] holds its last loaded value after draining. Sinks must qualify Y with Y_VALID.
- No beat is ever duplicated, reordered within a channel, or lost, except beats with out-of-range selects.

## Timing
- Latency: a beat accepted at edge n appears on Y with Y_VALID high after edge n, so it is first usable in cycle n+1.
- Throughput: one beat per cycle sustained to any single channel whose Y_READY is held high.
- IN_READY depends combinationally on S, the full flags, and Y_READY. There is no combinational path from IN to Y.
- Reset (synchronous, RST high at an edge):
  - All Y_VALID = 0, Y = 0, ERR = 0.
  - Lock state returns to IDLE.
  - Any beats held in the slots are discarded.
- While RST is high, IN_READY = 0.
- Reset asserted mid-packet or mid-stall takes effect at that same edge. Operation resumes on the first edge after RST deasserts.

## Configuration
- Macro STREAM_DMUX_LOCK_EN.
- Defined: the IN_LAST port exists and a two-state FSM is compiled in.
  - IDLE: E = S. A transfer with IN_LAST = 0 latches S into LOCK_SEL and moves to LOCKED.
  - LOCKED: E = LOCK_SEL and S is ignored. A transfer with IN_LAST = 1 returns to IDLE.
  - A single-beat packet (IN_LAST = 1 while IDLE) stays in IDLE.
  - An out-of-range LOCK_SEL drops every beat of the packet, with ERR pulsing once per dropped beat.
- Undefined: no IN_LAST port and no FSM. E = S on every beat.

## Test plan
- Reset: with all inputs at 0, hold RST high for 2 cycles -> Y_VALID = 4'b0000, Y = 0, ERR = 0, IN_READY = 0; after RST deasserts, IN_READY = 1.
- Routing: all Y_READY = 1; send IN = 8'hA0, A1, A2, A3 with S = 0, 1, 2, 3 on consecutive cycles -> each value appears on its own channel one cycle later; Y_VALID is one-hot per cycle.
- Backpressure: Y_READY[2] = 0; send 8'h55 to S = 2, then 8'h66 to S = 2 -> the second beat stalls with IN_READY = 0. Meanwhile 8'h77 sent to S = 1 is accepted. Raise Y_READY[2] -> 8'h55 drains, then 8'h66 arrives with no bubble.
- Full throughput: Y_READY[0] held high; 8 back-to-back beats to S = 0 -> 8 consecutive Y_VALID[0] cycles, data in order.
- Out of range: CH = 3, SW = 2, S = 3, IN = 8'hEE -> beat consumed, ERR high for exactly one cycle, all Y_VALID unchanged.
- Lock mode (STREAM_DMUX_LOCK_EN defined): beats 8'h10, 11, 12 with IN_LAST = 0, 0, 1 and S = 1, 3, 0 -> all three arrive on channel 1; the next beat with S = 2 goes to channel 2. Asserting RST during the packet clears the lock.
